// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage handshake between the pipeline and the hazard/stall controller.
// The pipeline (master) presents the decoded instruction; the controller (slave) answers stall/issue.
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 3
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic             id_rs_used;
    logic [REG_W-1:0] id_rt;
    logic             id_rt_used;
    logic [REG_W-1:0] id_rd;
    logic             id_writes;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic             issue;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_rd, id_writes, id_is_load, flush,
        input  stall, issue
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_rd, id_writes, id_is_load, flush,
        output stall, issue
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Scoreboard stall controller: per-register countdown of cycles until a result is readable.
// Macro FORWARDING_EN: bypass paths present (ALU latency 0, load latency 1); otherwise latency 2.
module hazard_stall_ctrl #(
    parameter int NREG  = 8,
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_ctrl_if.slave   id,
    output logic [NREG-1:0]      busy_mask,
    output logic [CNT_W-1:0]     stall_count
);
    logic [1:0] pend_reg  [NREG];
    logic [1:0] pend_next [NREG];
    logic [1:0] lat;
    logic       hit_rs;
    logic       hit_rt;
    logic       stall_int;
    logic       issue_int;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] stall_count_next;

`ifdef FORWARDING_EN
    assign lat = id.id_is_load ? 2'd1 : 2'd0;
`else
    // Without bypass paths the load flag cannot change the latency.
    assign lat = {1'b1, 1'b0 & id.id_is_load};
`endif

    // Sources are checked against the old entry, so a self-dependent write sees prior state.
    assign hit_rs    = id.id_rs_used & (pend_reg[id.id_rs] != 2'd0);
    assign hit_rt    = id.id_rt_used & (pend_reg[id.id_rt] != 2'd0);
    assign stall_int = id.id_valid & ~id.flush & ~rst & (hit_rs | hit_rt);
    assign issue_int = id.id_valid & ~id.flush & ~rst & ~stall_int;
    assign id.stall  = stall_int;
    assign id.issue  = issue_int;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
            always_comb begin
                pend_next[gi] = (pend_reg[gi] != 2'd0) ? pend_reg[gi] - 2'd1 : 2'd0;
                if (issue_int && id.id_writes && (id.id_rd == REG_W'(gi))) begin
                    pend_next[gi] = lat;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_reg[gi] <= 2'd0;
                end else begin
                    pend_reg[gi] <= pend_next[gi];
                end
            end

            assign busy_mask[gi] = (pend_reg[gi] != 2'd0);
        end
    endgenerate

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_int && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
        end
    end

    assign stall_count = stall_count_reg;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic against a
// ready-time scoreboard model (register r readable once cycle >= ready[r]).
module tb_hazard_stall_ctrl;
    localparam int NREG  = 8;
    localparam int REG_W = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
    localparam int ALU_STALLS  = 0;
    localparam int LOAD_STALLS = 1;
`else
    localparam int ALU_STALLS  = 2;
    localparam int LOAD_STALLS = 2;
`endif

    logic             clk;
    logic             rst;
    logic [NREG-1:0]  busy_mask;
    logic [CNT_W-1:0] stall_count;

    hazard_stall_ctrl_if #(.REG_W(REG_W)) bus ();

    hazard_stall_ctrl #(.NREG(NREG), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id          (bus.slave),
        .busy_mask   (busy_mask),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int ready [NREG];
    int exp_cnt = 0;
    bit known = 0;
    logic last_stall;
    logic last_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step(input bit r, input bit v, input int rs, input bit rsu,
                        input int rt, input bit rtu, input int rd, input bit w,
                        input bit ld, input bit fl);
        bit hit, es, ei;
        int lat;
        logic [NREG-1:0] em;
        logic [31:0] idx;
        rst = r;
        bus.id_valid   = v;
        idx = rs; bus.id_rs = idx[REG_W-1:0];
        bus.id_rs_used = rsu;
        idx = rt; bus.id_rt = idx[REG_W-1:0];
        bus.id_rt_used = rtu;
        idx = rd; bus.id_rd = idx[REG_W-1:0];
        bus.id_writes  = w;
        bus.id_is_load = ld;
        bus.flush      = fl;
        @(negedge clk);
        hit = (rsu && cyc < ready[rs]) || (rtu && cyc < ready[rt]);
        es  = v && !fl && !r && hit;
        ei  = v && !fl && !r && !es;
        for (int k = 0; k < NREG; k++) em[k] = (cyc < ready[k]);
        last_stall = bus.stall;
        last_issue = bus.issue;
        chk("stall", 32'(bus.stall), 32'(es));
        chk("issue", 32'(bus.issue), 32'(ei));
        if (known) begin
            chk("busy_mask", 32'(busy_mask), 32'(em));
            chk("stall_count", 32'(stall_count), exp_cnt);
        end
        @(posedge clk);
`ifdef FORWARDING_EN
        lat = ld ? 1 : 0;
`else
        lat = 2;
`endif
        if (r) begin
            for (int k = 0; k < NREG; k++) ready[k] = 0;
            exp_cnt = 0;
            known = 1;
        end else begin
            if (es && exp_cnt < CMAX) exp_cnt++;
            if (ei && w) ready[rd] = cyc + lat + 1;
        end
        cyc++;
        #1;
    endtask

    // Plain instruction in ID: no reset, no flush.
    task automatic op(input int rs, input bit rsu, input int rt, input bit rtu,
                      input int rd, input bit w, input bit ld);
        step(0, 1, rs, rsu, rt, rtu, rd, w, ld, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Present the same consumer until it issues; returns the number of stall cycles.
    task automatic consume(input int rs, input int rt, input int rd, output int nst);
        nst = 0;
        for (int k = 0; k < 6; k++) begin
            op(rs, 1, rt, 1, rd, 1, 0);
            if (last_issue === 1'b1) break;
            nst++;
        end
        chk("consumer_issued", 32'(last_issue), 32'd1);
    endtask

    int nst;

    initial begin
        for (int k = 0; k < NREG; k++) ready[k] = 0;
        rst = 1'b0;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rs_used = 0; bus.id_rt = '0;
        bus.id_rt_used = 0; bus.id_rd = '0; bus.id_writes = 0; bus.id_is_load = 0;
        bus.flush = 0;

        // Reset state
        do_reset();
        chk("reset_busy", 32'(busy_mask), 32'h0);
        chk("reset_count", 32'(stall_count), 32'h0);

        // ADD r1 then ADD r2,r1,r3
        op(0, 0, 0, 0, 1, 1, 0);
        if (ALU_STALLS > 0) begin
            op(1, 1, 3, 1, 2, 1, 0);
            chk("t1_busy_in_stall", 32'(busy_mask), 32'h02);
            consume(1, 3, 2, nst);
            nst++;
        end else begin
            consume(1, 1, 2, nst);
        end
        chk("t1_stall_cycles", nst, ALU_STALLS);
        chk("t1_count", 32'(stall_count), ALU_STALLS);

        // LD r4 then ADD r5,r4,r0
        do_reset();
        op(0, 0, 0, 0, 4, 1, 1);
        chk("t2_busy_after_load", 32'(busy_mask), 32'h10);
        consume(4, 0, 5, nst);
        chk("t2_load_use_stalls", nst, LOAD_STALLS);

        // Independent stream and unused sources
        do_reset();
        op(0, 0, 0, 0, 1, 1, 0);
        op(0, 0, 0, 0, 2, 1, 0);
        op(0, 1, 7, 1, 3, 1, 0);
        op(1, 0, 2, 0, 4, 1, 0);
        chk("t3_issue", 32'(last_issue), 32'd1);
        chk("t3_count", 32'(stall_count), 32'h0);

        // Flush during a stall on r6
        do_reset();
        op(0, 0, 0, 0, 6, 1, 0);
        op(6, 1, 0, 0, 1, 1, 0);
        step(0, 1, 6, 1, 0, 0, 1, 1, 0, 1);
        chk("t4_flush_stall", 32'(last_stall), 32'd0);
        chk("t4_flush_issue", 32'(last_issue), 32'd0);
        op(0, 1, 7, 1, 2, 1, 0);
        chk("t4_unrelated_issue", 32'(last_issue), 32'd1);
        chk("t4_r6_cleared", 32'(busy_mask[6]), 32'd0);

        // Reset mid-stall
        do_reset();
        op(0, 0, 0, 0, 3, 1, 1);
        op(3, 1, 0, 0, 5, 1, 0);
        step(1, 1, 3, 1, 0, 0, 5, 1, 0, 0);
        chk("t5_stall_in_rst", 32'(last_stall), 32'd0);
        chk("t5_busy_after", 32'(busy_mask), 32'h0);
        chk("t5_count_after", 32'(stall_count), 32'h0);
        op(3, 1, 0, 0, 5, 1, 0);
        chk("t5_issue_after_rst", 32'(last_issue), 32'd1);

        // Stall counter saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            op(0, 0, 0, 0, 1, 1, 1);
            consume(1, 0, 2, nst);
        end
        chk("t6_count_sat", 32'(stall_count), CMAX);
        op(0, 0, 0, 0, 1, 1, 1);
        op(1, 1, 0, 0, 2, 1, 0);
        chk("t6_count_hold", 32'(stall_count), CMAX);

        // Random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                 $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                 $urandom_range(0, NREG - 1), $urandom_range(0, 99) < 70,
                 $urandom_range(0, 1),
                 $urandom_range(0, 99) < 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
